// File: rtl/dma_pkg.sv
// Shared types and constants for the Wishbone read-burst DMA master.
package dma_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StBurst = 3'd2,
    StGap   = 3'd3,
    StDone  = 3'd4
  } dma_state_e;

  localparam logic [3:0]  WB_SEL_ALL = 4'hf;
  localparam logic [31:0] WB_ADR_INC = 32'd4;

endpackage

// File: rtl/dma_rd_fifo.sv
// Synchronous first-word-fall-through FIFO of 32-bit words, depth 2**AW.
module dma_rd_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [31:0]   wr_dat_i,
  input  logic          rd_en_i,
  output logic [31:0]   rd_dat_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   free_o
);

  localparam int unsigned Depth = 1 << AW;

  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_ok, rd_ok;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == (AW+1)'(Depth));
  assign free_o   = (AW+1)'(Depth) - cnt_q;
  assign rd_dat_o = mem_q[rptr_q];

  // A write into a full FIFO is legal only when a read frees the slot this cycle.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_en_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      if (wr_ok && !rd_ok)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (!wr_ok && rd_ok) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/dma_wbm_rd.sv
// Wishbone read-burst master feeding a valid/ready word stream through a FWFT FIFO.
// Optional consecutive-retry limit enabled by defining DMA_RD_RTY_LIMIT_EN.
module dma_wbm_rd
  import dma_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned RTY_GAP   = 4,
  parameter int unsigned MAX_RTY   = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_adr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      wbm_adr_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_cab_o,
  output logic             wbm_pref_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_rty_i,
  input  logic             wbm_err_i,
  output logic [31:0]      dat_o,
  output logic             dat_valid_o,
  input  logic             dat_ready_i
);

  localparam int unsigned GapW = $clog2(RTY_GAP + 1);

  dma_state_e       state_q, state_d;
  logic [31:0]      adr_q, adr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] bcnt_q, bcnt_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             cyc_q, cyc_d;
  logic             cab_q, cab_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [LEN_W-1:0] blen;
  logic             fifo_wr, fifo_empty, fifo_full;
  logic [FIFO_AW:0] fifo_free;

`ifdef DMA_RD_RTY_LIMIT_EN
  localparam int unsigned RtyW = $clog2(MAX_RTY + 1);
  logic [RtyW-1:0] rty_cnt_q, rty_cnt_d;
`endif

  logic unused_sig;
`ifdef DMA_RD_RTY_LIMIT_EN
  assign unused_sig = ^{cmd_adr_i[1:0], fifo_full};
`else
  assign unused_sig = ^{cmd_adr_i[1:0], fifo_full, 32'(MAX_RTY)};
`endif

  assign blen = (rem_q > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : rem_q;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    rem_d       = rem_q;
    bcnt_d      = bcnt_q;
    gap_d       = gap_q;
    cyc_d       = cyc_q;
    cab_d       = cab_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    fifo_wr     = 1'b0;
`ifdef DMA_RD_RTY_LIMIT_EN
    rty_cnt_d   = rty_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          adr_d       = {cmd_adr_i[31:2], 2'b00};
          rem_d       = cmd_len_i;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
`ifdef DMA_RD_RTY_LIMIT_EN
          rty_cnt_d   = '0;
`endif
          state_d     = (cmd_len_i == '0) ? StDone : StWait;
        end
      end
      StWait: begin
        // Only issue a burst once the FIFO can absorb all of it.
        if (LEN_W'(fifo_free) >= blen) begin
          bcnt_d  = blen;
          cyc_d   = 1'b1;
          cab_d   = (blen > LEN_W'(1));
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (wbm_err_i) begin
          cyc_d   = 1'b0;
          cab_d   = 1'b0;
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = StDone;
        end else if (wbm_rty_i) begin
          cyc_d = 1'b0;
          cab_d = 1'b0;
`ifdef DMA_RD_RTY_LIMIT_EN
          if (rty_cnt_q >= RtyW'(MAX_RTY)) begin
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = StDone;
          end else begin
            rty_cnt_d = rty_cnt_q + RtyW'(1);
            gap_d     = GapW'(RTY_GAP);
            state_d   = StGap;
          end
`else
          gap_d   = GapW'(RTY_GAP);
          state_d = StGap;
`endif
        end else if (wbm_ack_i) begin
          fifo_wr = 1'b1;
          adr_d   = adr_q + WB_ADR_INC;
          rem_d   = rem_q - LEN_W'(1);
          bcnt_d  = bcnt_q - LEN_W'(1);
`ifdef DMA_RD_RTY_LIMIT_EN
          rty_cnt_d = '0;
`endif
          if (bcnt_q == LEN_W'(1)) begin
            cyc_d   = 1'b0;
            cab_d   = 1'b0;
            state_d = (rem_q == LEN_W'(1)) ? StDone : StWait;
          end
        end
      end
      StGap: begin
        if (gap_q <= GapW'(1)) state_d = StWait;
        else                   gap_d   = gap_q - GapW'(1);
      end
      StDone: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      rem_q       <= '0;
      bcnt_q      <= '0;
      gap_q       <= '0;
      cyc_q       <= 1'b0;
      cab_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef DMA_RD_RTY_LIMIT_EN
      rty_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      rem_q       <= rem_d;
      bcnt_q      <= bcnt_d;
      gap_q       <= gap_d;
      cyc_q       <= cyc_d;
      cab_q       <= cab_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef DMA_RD_RTY_LIMIT_EN
      rty_cnt_q   <= rty_cnt_d;
`endif
    end
  end

  dma_rd_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .wr_en_i  (fifo_wr),
    .wr_dat_i (wbm_dat_i),
    .rd_en_i  (dat_ready_i),
    .rd_dat_o (dat_o),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full),
    .free_o   (fifo_free)
  );

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_sel_o   = WB_SEL_ALL;
  assign wbm_we_o    = 1'b0;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_cab_o   = cab_q;
  assign wbm_pref_o  = cab_q;
  assign dat_valid_o = ~fifo_empty;

endmodule

// File: doc/dma_wbm_rd.md
Name: dma_wbm_rd

Overview:
Wishbone read-burst master that sits directly upstream of the PCI bridge and drives its wbm_* master-side inputs (bridge target side).
- Accepts a (start address, word count) read command.
- Splits the command into bursts of up to MAX_BURST words, using wbm_cab_o/wbm_pref_o so the bridge prefetches from PCI.
- Buffers the returned 32-bit words in an internal FIFO and presents them as a valid/ready stream to the DMA datapath.
- Handles bridge retry (wbm_rty_i) with back-off, and bus error (wbm_err_i) with abort.

Parameters:
- FIFO_AW, 4: log2 of FIFO depth in 32-bit words (depth 16).
- MAX_BURST, 8: maximum words per Wishbone burst (1..2^FIFO_AW).
- LEN_W, 16: width of the command word count.
- RTY_GAP, 4: idle cycles after a retry before re-issuing (>=1).
- MAX_RTY, 255: consecutive-retry limit; used only with the optional feature.

Ports:
- wb_clk_i, in, 1: clock (the PCI clock domain).
- wb_rst_i, in, 1: reset, asynchronous, active-high.
- cmd_valid_i, in, 1: command request.
- cmd_ready_o, out, 1: command accepted when cmd_valid_i and cmd_ready_o are both high.
- cmd_adr_i, in, 32: byte start address; bits [1:0] are ignored and treated as 0.
- cmd_len_i, in, LEN_W: number of 32-bit words to read.
- busy_o, out, 1: a command is in progress.
- done_o, out, 1: one-cycle pulse when a command has finished on the bus.
- err_o, out, 1: status of the last command; valid with done_o and held until the next accept.
- wbm_adr_o, out, 32: burst word address.
- wbm_sel_o, out, 4: byte selects, always 4'hf.
- wbm_we_o, out, 1: always 0.
- wbm_cyc_o, out, 1: bus cycle.
- wbm_stb_o, out, 1: strobe.
- wbm_cab_o, out, 1: consecutive-address burst.
- wbm_pref_o, out, 1: prefetch hint.
- wbm_dat_i, in, 32: read data.
- wbm_ack_i, in, 1: acknowledge.
- wbm_rty_i, in, 1: retry.
- wbm_err_i, in, 1: error.
- dat_o, out, 32: stream data from the FIFO head.
- dat_valid_o, out, 1: stream valid (FIFO not empty).
- dat_ready_i, in, 1: stream ready; a word transfers when dat_valid_o and dat_ready_i are both high.

Behaviour:
Reset values (asynchronous on wb_rst_i):
- All Wishbone controls 0; wbm_adr_o 0; wbm_sel_o 4'hf.
- cmd_ready_o 1; busy_o, done_o, err_o, dat_valid_o 0.
- FIFO emptied.
- Reset mid-burst drops wbm_cyc_o/wbm_stb_o immediately; no completion is reported.

State machine: IDLE, WAIT, BURST, GAP, DONE. All outputs are registered.

IDLE
- cmd_ready_o=1.
- On accept: latch address {cmd_adr_i[31:2],2'b00}, set remaining=cmd_len_i, clear err_o, set busy_o.
- If cmd_len_i==0, go to DONE; otherwise go to WAIT.

WAIT
- Compute blen = min(remaining, MAX_BURST).
- When FIFO free space >= blen: load the burst counter with blen and go to BURST.
- In the next cycle, wbm_cyc_o and wbm_stb_o are 1, and wbm_cab_o = wbm_pref_o = (blen>1).

BURST
- Each ack writes wbm_dat_i to the FIFO, increments the address by 4 (modulo 2^32), and decrements remaining and the burst counter.
- On the ack of the last word of the burst, cyc/stb/cab/pref deassert on the next clock.
  - Then go to DONE if remaining==0, else to WAIT.
- Zero-wait back-to-back acks must be sustained at 1 word/cycle.
- Priority when signals coincide: err > rty > ack. An ack coincident with rty or err is ignored (no FIFO write, no count change).
- wbm_rty_i: deassert the bus next clock, go to GAP. Words already acked are kept; the address holds the next un-acked word.
- wbm_err_i: deassert the bus next clock, set err_o=1, discard the remaining count, go to DONE.

GAP
- Count RTY_GAP cycles with the bus idle, then go to WAIT.
- The burst is recomputed from the current address and remaining count.

DONE
- done_o=1 for exactly one cycle, busy_o goes to 0, then return to IDLE.
- Completion does not wait for the FIFO to drain.

FIFO and stream
- Space is reserved before each burst, so the FIFO never overflows.
- A write and a read in the same cycle are both allowed when the FIFO is full or empty-plus-one.
- dat_o is valid in the same cycle as dat_valid_o (first-word fall-through).
- Latency: the first acked word appears on dat_o one cycle after its ack.
- The FIFO drains independently of the state machine. Draining continues after an error; words already buffered remain valid.
- cmd_valid_i held high while busy is not accepted until the state machine is back in IDLE.

Optional Feature:
DMA_RD_RTY_LIMIT_EN.
- Defined: a counter of consecutive retries (reset by any valid ack or by a command accept) is kept. When a retry would make the count exceed MAX_RTY, the block ends as for an error: err_o=1, go to DONE.
- Undefined: retries are unlimited and there is no counter logic.

Decomposition:
Shared package dma_pkg holds:
- State encoding constants for IDLE, WAIT, BURST, GAP, DONE.
- WB_SEL_ALL=4'hf.
- The word-address increment constant.

Sub-module dma_rd_fifo: synchronous FWFT FIFO.
- Parameter AW.
- Ports: wr_en, wr_dat, rd_en, rd_dat, empty, full, free count [AW:0].

Test Plan:
1. cmd adr=0x1000, len=20, always-ack slave, dat_ready=1:
   - Bursts of 8, 8, 4 at 0x1000/0x1020/0x1040; cab=1 throughout.
   - 20 words arrive in order; done_o pulses once; err_o=0.
2. len=1:
   - A single cycle with cab=0 and pref=0; one word; done_o.
3. len=0:
   - No wbm_cyc_o activity; done_o pulses 2 cycles after accept.
4. Retry on the 3rd ack of the first burst (len=8, RTY_GAP=4):
   - Bus idle for 4 cycles, then a re-issue at 0x1008 with 6 words.
   - 8 correct words delivered in total.
5. dat_ready=0, len=40, FIFO_AW=4:
   - After 16 words no new burst is issued (bus idle).
   - Raising dat_ready resumes transfers; all 40 words are delivered in order.
6. wbm_err_i on word 5 of a len=12 command:
   - Bus drops the next cycle; done_o with err_o=1; the 4 good words drain.
   - With DMA_RD_RTY_LIMIT_EN and MAX_RTY=3, a slave that always retries causes err_o=1 after the 4th retry.
